decimate: RTL and testbench

- R-to-1 decimator. It is the receive-side counterpart of the zero-stuffing interpolator.
- Consumes a qualified input stream, groups every R valid samples into a frame, and emits one output sample per frame.
- Two frame modes:
  - pick: keep one selected sample of the frame.
  - integrate-and-dump: sum all R samples of the frame.
- Sits after the pulse-compression filter chain to return the upsampled stream to the base rate.

---
 rtl/decimate.sv | 116 +++++++++++
 tb/tb_decimate.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decimate.sv
// R-to-1 decimator. It groups every R qualified input samples into a frame
// and emits one saturated output sample per completed frame. In pick mode the
// output is the frame's sample at index PHASE. In integrate-and-dump mode the
// output is the sum of all R samples in the frame.
module decimate #(
  parameter int R            = 4,
  parameter int INPUT_WIDTH  = 22,
  parameter int OUTPUT_WIDTH = 14,
  parameter int SHIFT        = 0,
  parameter int PHASE        = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  Xin,
  input  logic                    Xin_valid,
  input  logic                    mode,
  input  logic                    sync,
  output logic [OUTPUT_WIDTH-1:0] Xout,
  output logic                    Xout_valid,
  output logic                    ovf
);

  localparam int PW = $clog2(R);
  localparam int AW = INPUT_WIDTH + PW;

  localparam logic [PW-1:0] LAST_PH = PW'(R - 1);
  localparam logic [PW-1:0] PICK_PH = PW'(PHASE);

  // Output clamp limits, sign-extended to the accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [PW-1:0]           phase_q, phase_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic                    mode_q, mode_d;
  logic [OUTPUT_WIDTH-1:0] xout_q, xout_d;
  logic                    xout_valid_q, xout_valid_d;
  logic                    ovf_q, ovf_d;

  logic                    start;
  logic                    frame_mode;
  logic [PW-1:0]           cur_phase;
  logic signed [AW-1:0]    xin_ext;
  logic signed [AW-1:0]    shifted;
  logic signed [AW-1:0]    sat_val;
  logic                    clip;

  assign xin_ext = {{PW{Xin[INPUT_WIDTH-1]}}, Xin};

  // Next-state logic: phase tracking, accumulation, and frame completion.
  // A sync pulse rewinds to phase 0, so a valid sample in the same cycle
  // starts a new frame instead of closing the old one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    phase_d      = phase_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    xout_d       = xout_q;
    xout_valid_d = 1'b0;
    ovf_d        = 1'b0;
    start        = sync || (phase_q == '0);
    cur_phase    = sync ? '0 : phase_q;
    frame_mode   = start ? mode : mode_q;

    if (sync) phase_d = '0;

    if (Xin_valid) begin
      phase_d = (cur_phase == LAST_PH) ? '0 : cur_phase + PW'(1);
      if (start) mode_d = mode;
      if (frame_mode) acc_d = start ? xin_ext : acc_q + xin_ext;
      else if (cur_phase == PICK_PH) acc_d = xin_ext;
    end

    shifted = acc_d >>> SHIFT;
    clip    = 1'b0;
    sat_val = shifted;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX;
      clip    = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN;
      clip    = 1'b1;
    end

    if (Xin_valid && !sync && (phase_q == LAST_PH)) begin
      xout_d       = sat_val[OUTPUT_WIDTH-1:0];
      xout_valid_d = 1'b1;
      ovf_d        = clip;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      phase_q      <= '0;
      acc_q        <= '0;
      mode_q       <= 1'b0;
      xout_q       <= '0;
      xout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      xout_q       <= xout_d;
      xout_valid_q <= xout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign Xout       = xout_q;
  assign Xout_valid = xout_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_decimate.sv
// Testbench for decimate. A reference model keeps the current frame as a
// queue of samples. When the queue holds R samples, the model computes the
// expected output (pick or sum, then shift and clamp). Directed scenarios also
// compare against literal expected values. A randomized run closes the bench.
module tb_decimate;

  localparam int R     = 4;
  localparam int IW    = 22;
  localparam int OW    = 14;
  localparam int SHIFT = 0;
  localparam int PHASE = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] xin;
  logic          xin_valid;
  logic          mode;
  logic          sync;
  logic [OW-1:0] xout;
  logic          xout_valid;
  logic          ovf;

  decimate #(.R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SHIFT), .PHASE(PHASE)) dut (
    .clk(clk), .rst_n(rst_n), .Xin(xin), .Xin_valid(xin_valid), .mode(mode), .sync(sync),
    .Xout(xout), .Xout_valid(xout_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int            frame_q[$];
  logic          frame_mode;
  logic          exp_valid;
  logic          exp_ovf;
  logic [OW-1:0] exp_xout;

  // Drive one cycle of inputs, clock it, advance the model, and settle past the edge.
  task automatic step(input logic r, input logic v, input int x, input logic m, input logic s);
    longint res;
    longint lim_hi;
    longint lim_lo;
    @(negedge clk);
    rst_n = r; xin_valid = v; xin = x[IW-1:0]; mode = m; sync = s;
    @(posedge clk);
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    if (!r) begin
      frame_q.delete();
      exp_xout = '0;
    end else begin
      if (s) frame_q.delete();
      if (v) begin
        if (frame_q.size() == 0) frame_mode = m;
        frame_q.push_back(x);
        if (frame_q.size() == R) begin
          res = 0;
          if (frame_mode) foreach (frame_q[i]) res += frame_q[i];
          else res = frame_q[PHASE];
          res    = res >>> SHIFT;
          lim_hi = (64'sd1 <<< (OW - 1)) - 1;
          lim_lo = -(64'sd1 <<< (OW - 1));
          if (res > lim_hi) begin res = lim_hi; exp_ovf = 1'b1; end
          if (res < lim_lo) begin res = lim_lo; exp_ovf = 1'b1; end
          exp_xout  = res[OW-1:0];
          exp_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    n_vec++;
    if (xout !== '0) begin n_err++; $display("FAIL reset_xout got=%0d want=0", $signed(xout)); end
    n_vec++;
    if (xout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", xout_valid); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf); end
  endtask

  // Continuous samples 1..8 in the given mode; expect pulses after samples 4 and 8.
  task automatic run_1_to_8(input logic m, input int want0, input int want1, input string tag);
    step(1'b1, 1'b0, 0, m, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, i, m, 1'b0);
      n_vec++;
      if (xout_valid !== ((i == 4) || (i == 8)) || ovf !== 1'b0) begin
        n_err++; $display("FAIL %s_pulse i=%0d got v=%b o=%b", tag, i, xout_valid, ovf);
      end
      if (i == 4 || i == 8) begin
        n_vec++;
        if ($signed(xout) != ((i == 4) ? want0 : want1)) begin
          n_err++; $display("FAIL %s_xout i=%0d got=%0d want=%0d", tag, i, $signed(xout), (i == 4) ? want0 : want1);
        end
      end
    end
  endtask

  task automatic test_pick;      run_1_to_8(1'b0, 1, 5, "pick");       endtask
  task automatic test_integrate; run_1_to_8(1'b1, 10, 26, "integrate"); endtask

  task automatic test_saturation;
    int vals[3]  = '{5000, -5000, 2047};
    int wants[3] = '{8191, -8192, 8188};
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, vals[k], 1'b1, 1'b0);
      n_vec++;
      if (xout_valid !== 1'b1 || $signed(xout) != wants[k] || ovf !== (k != 2)) begin
        n_err++; $display("FAIL sat k=%0d got v=%b x=%0d o=%b want x=%0d o=%b",
                          k, xout_valid, $signed(xout), ovf, wants[k], k != 2);
      end
    end
  endtask

  task automatic test_gapped;
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 2 * i, 1'b1, 1'b0);
      n_vec++;
      if (xout_valid !== (i == 4)) begin n_err++; $display("FAIL gap_pulse i=%0d got=%b", i, xout_valid); end
      if (i < 4) begin
        step(1'b1, 1'b0, 99, 1'b1, 1'b0);
        step(1'b1, 1'b0, 99, 1'b1, 1'b0);
      end
    end
    n_vec++;
    if ($signed(xout) != 20) begin n_err++; $display("FAIL gap_xout got=%0d want=20", $signed(xout)); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 55, 1'b1, 1'b0);
      n_vec++;
      if (xout_valid !== 1'b0 || $signed(xout) != 20) begin
        n_err++; $display("FAIL gap_hold got v=%b x=%0d want v=0 x=20", xout_valid, $signed(xout));
      end
    end
  endtask

  task automatic test_sync;
    int seq_x[6] = '{7, 7, 100, 101, 102, 103};
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, seq_x[i], 1'b1, i == 2);
      n_vec++;
      if (xout_valid !== (i == 5)) begin n_err++; $display("FAIL sync_pulse i=%0d got=%b", i, xout_valid); end
    end
    n_vec++;
    if ($signed(xout) != 406) begin n_err++; $display("FAIL sync_xout got=%0d want=406", $signed(xout)); end
    // Sync on the phase-3 valid: no output; that sample starts a new frame.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 10 + i, 1'b1, i == 3);
      n_vec++;
      if (xout_valid !== (i == 6)) begin n_err++; $display("FAIL sync3_pulse i=%0d got=%b", i, xout_valid); end
    end
    n_vec++;
    if ($signed(xout) != 13 + 14 + 15 + 16) begin
      n_err++; $display("FAIL sync3_xout got=%0d want=%0d", $signed(xout), 13 + 14 + 15 + 16);
    end
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 50, 1'b1, 1'b0);
    step(1'b0, 1'b1, 50, 1'b1, 1'b0);
    n_vec++;
    if (xout !== '0 || xout_valid !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs got x=%0d v=%b o=%b want all 0", $signed(xout), xout_valid, ovf);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1, 1'b1, 1'b0);
    n_vec++;
    if (xout_valid !== 1'b1 || $signed(xout) != 4) begin
      n_err++; $display("FAIL midrst_frame got v=%b x=%0d want v=1 x=4", xout_valid, $signed(xout));
    end
  endtask

  task automatic test_mode_change;
    int a[4] = '{3, 5, 7, 9};
    int b[4] = '{10, 20, 30, 40};
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, a[i], i < 2, 1'b0);
    n_vec++;
    if (xout_valid !== 1'b1 || $signed(xout) != 24) begin
      n_err++; $display("FAIL mode_int got v=%b x=%0d want v=1 x=24", xout_valid, $signed(xout));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, b[i], 1'b0, 1'b0);
    n_vec++;
    if (xout_valid !== 1'b1 || $signed(xout) != 10) begin
      n_err++; $display("FAIL mode_pick got v=%b x=%0d want v=1 x=10", xout_valid, $signed(xout));
    end
  endtask

  task automatic test_random;
    int x;
    logic v, s, r, m;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 19) == 0);
      m = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) x = $signed($urandom) >>> (32 - IW);
      else x = $urandom_range(0, 8000) - 4000;
      step(r, v, x, m, s);
      n_vec++;
      if (xout_valid !== exp_valid || ovf !== exp_ovf || xout !== exp_xout) begin
        n_err++; $display("FAIL random n=%0d got v=%b o=%b x=%0d want v=%b o=%b x=%0d",
                          n, xout_valid, ovf, $signed(xout), exp_valid, exp_ovf, $signed(exp_xout));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; xin_valid = 1'b0; xin = '0; mode = 1'b0; sync = 1'b0;
    exp_xout = '0; exp_valid = 1'b0; exp_ovf = 1'b0; frame_mode = 1'b0;
    test_reset;
    test_pick;
    test_integrate;
    test_saturation;
    test_gapped;
    test_sync;
    test_mid_reset;
    test_mode_change;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
